divider_unit: RTL and testbench

Iterative RV32M divide/remainder unit that runs beside the single-cycle ALU in the execute stage. It accepts one 32-bit operand pair per request and computes DIV, DIVU, REM or REMU with a restoring shift-subtract algorithm, one quotient bit per cycle. It raises `busy` so the hazard logic can stall the pipeline, and pulses `done` when the result is ready. `flush` cancels an operation in flight on a branch or pipeline kill.

---
 rtl/divider_unit.sv | 168 ++++++++++++++++
 tb/tb_divider_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// divider_unit: iterative RV32M DIV/DIVU/REM/REMU using restoring shift-subtract,
// producing one quotient bit per cycle alongside the single-cycle ALU.
module divider_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      DivOp,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] DivResult
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] ZERO      = '0;
   localparam logic [XLEN-1:0] ALL_ONES  = '1;
   localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [4:0]      LAST_ITER = 5'd31;

   state_t state;
   state_t next_state;

   // Latched request. Signedness is folded into the sign bits, which are
   // only set for DIV/REM, so the result fix only needs to know quo vs rem.
   logic            op_rem;
   logic            a_sign;
   logic            b_sign;
   logic [XLEN:0]   rem_reg;
   logic [XLEN-1:0] quo_reg;
   logic [XLEN-1:0] divisor;
   logic [4:0]      count;

   logic            accept;
   logic            req_signed;
   logic            req_rem;
   logic            div_by_zero;
   logic            overflow;
   logic            special;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic [XLEN-1:0] special_result;

   logic [XLEN+1:0] trial;
   logic [XLEN:0]   rem_next;
   logic [XLEN-1:0] quo_next;
   logic [XLEN-1:0] quo_fixed;
   logic [XLEN-1:0] rem_fixed;
   logic [XLEN-1:0] final_result;

   assign accept = (state == IDLE) && start && !flush;

   // Decode the incoming request: magnitudes and the early-out special cases
   always_comb begin
      req_signed  = ~DivOp[0];
      req_rem     = DivOp[1];
      div_by_zero = (B == ZERO);
      overflow    = req_signed && (A == MIN_NEG) && (B == ALL_ONES);
      special     = div_by_zero || overflow;
      abs_a       = (req_signed && A[XLEN-1]) ? (ZERO - A) : A;
      abs_b       = (req_signed && B[XLEN-1]) ? (ZERO - B) : B;
      if (div_by_zero) begin
         special_result = req_rem ? A : ALL_ONES;
      end else begin
         special_result = req_rem ? ZERO : MIN_NEG;
      end
   end

   // One restoring step: shift rem:quo left, try subtracting the divisor, keep if non-negative
   always_comb begin
      trial = {rem_reg, quo_reg[XLEN-1]} - {2'b00, divisor};
      if (!trial[XLEN+1]) begin
         rem_next = trial[XLEN:0];
         quo_next = {quo_reg[XLEN-2:0], 1'b1};
      end else begin
         rem_next = {rem_reg[XLEN-1:0], quo_reg[XLEN-1]};
         quo_next = {quo_reg[XLEN-2:0], 1'b0};
      end
   end

   // Sign-correct the final step's quotient/remainder for the signed ops
   always_comb begin
      quo_fixed    = (a_sign ^ b_sign) ? (ZERO - quo_next) : quo_next;
      rem_fixed    = a_sign ? (ZERO - rem_next[XLEN-1:0]) : rem_next[XLEN-1:0];
      final_result = op_rem ? rem_fixed : quo_fixed;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and status outputs; flush overrides every transition
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = special ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (count == LAST_ITER) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (flush) begin
         next_state = IDLE;
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, write the result only when entering DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_rem    <= 1'b0;
         a_sign    <= 1'b0;
         b_sign    <= 1'b0;
         rem_reg   <= '0;
         quo_reg   <= '0;
         divisor   <= '0;
         count     <= '0;
         DivResult <= '0;
      end else if (accept) begin
         op_rem  <= req_rem;
         a_sign  <= req_signed & A[XLEN-1];
         b_sign  <= req_signed & B[XLEN-1];
         rem_reg <= '0;
         quo_reg <= abs_a;
         divisor <= abs_b;
         count   <= '0;
         if (special) begin
            DivResult <= special_result;
         end
      end else if ((state == CALC) && !flush) begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
         count   <= count + 5'd1;
         if (count == LAST_ITER) begin
            DivResult <= final_result;
         end
      end
   end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: table vectors, randomized ops against an arithmetic reference,
// and hand-written flush / ignored-start / reset sequences.
module tb_divider_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  DivOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] DivResult;

   int total;
   int bad;
   int doneCount;
   logic [31:0] heldResult;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   divider_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .DivOp     (DivOp),
      .A         (A),
      .B         (B),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .DivResult (DivResult)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every done pulse seen, so sequences can prove no unexpected done appeared
   always @(negedge clk) begin
      if (done === 1'b1) doneCount++;
   end

   // Watchdog so the run can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: plain integer division, with divide-by-zero as defined for RV32M
   function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
      if (op[0] == 1'b0) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return op[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic int refLatency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (op[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Present one request for one cycle, then scramble inputs to prove they were latched
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      DivOp = op;
      A     = a;
      B     = b;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      DivOp = 2'($urandom_range(0, 3));
      A     = $urandom;
      B     = $urandom;
   endtask

   // Wait (bounded) for done, then check result, latency, busy and the return to IDLE
   task automatic waitResult(input string name, input logic [31:0] exp, input int lat);
      int cyc;
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            cyc  = i;
            break;
         end
         stepCycle();
      end
      checkOutput({name, " done seen"}, 32'(seen), 32'd1);
      if (seen) begin
         checkOutput({name, " result"}, DivResult, exp);
         checkOutput({name, " latency"}, 32'(cyc), 32'(lat));
         checkOutput({name, " busy in done"}, 32'(busy), 32'd1);
         stepCycle();
         @(negedge clk);
         checkOutput({name, " idle busy/done"}, {30'd0, busy, done}, 32'd0);
         checkOutput({name, " result held"}, DivResult, exp);
         heldResult = exp;
      end
   endtask

   initial begin
      int cnt;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int kind;

      total = 0;
      bad = 0;
      doneCount = 0;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      DivOp = 2'd0;
      A = 32'd0;
      B = 32'd0;

      vecs[0]  = '{2'd0, 32'd100,        32'd7,          32'd14,         33};
      vecs[1]  = '{2'd2, 32'd100,        32'd7,          32'd2,          33};
      vecs[2]  = '{2'd0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
      vecs[3]  = '{2'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
      vecs[4]  = '{2'd1, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   33};
      vecs[5]  = '{2'd1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   1};
      vecs[6]  = '{2'd3, 32'h12345678,   32'd0,          32'h12345678,   1};
      vecs[7]  = '{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
      vecs[8]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
      vecs[9]  = '{2'd3, 32'hFFFFFFFF,   32'd1,          32'd0,          33};
      vecs[10] = '{2'd0, 32'd7,          32'hFFFFFFF9,   32'hFFFFFFFF,   33};
      vecs[11] = '{2'd0, 32'h80000000,   32'd1,          32'h80000000,   33};
      vecs[12] = '{2'd2, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1};

      // Reset state
      repeat (3) stepCycle();
      @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset result", DivResult, 32'd0);
      rst_n = 1'b1;
      stepCycle();
      heldResult = 32'd0;

      // Directed table
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         waitResult($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat);
      end

      // Randomized operations with biased corner operands
      for (int i = 0; i < 40; i++) begin
         op   = 2'($urandom_range(0, 3));
         kind = $urandom_range(0, 7);
         a    = $urandom;
         b    = $urandom;
         case (kind)
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: b = b >> $urandom_range(0, 31);
            4: a = 32'($urandom_range(0, 100));
            default: ;
         endcase
         applyStimulus(op, a, b);
         waitResult($sformatf("rand%0d op=%0d a=%h b=%h", i, op, a, b), refResult(op, a, b), refLatency(op, a, b));
      end

      // Flush mid-CALC: busy drops, no done, result untouched, then a fresh op works
      cnt = doneCount;
      applyStimulus(2'd1, 32'd1000, 32'd3);
      repeat (9) stepCycle();
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flush busy", 32'(busy), 32'd0);
      checkOutput("flush done", 32'(done), 32'd0);
      checkOutput("flush result kept", DivResult, heldResult);
      applyStimulus(2'd1, 32'd1000, 32'd3);
      waitResult("after flush", 32'd333, 33);
      stepCycle();
      checkOutput("flush done count", 32'(doneCount - cnt), 32'd1);

      // Flush in the DONE cycle still shows done, then returns to IDLE
      applyStimulus(2'd1, 32'h12345678, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flush in done: done", 32'(done), 32'd1);
      checkOutput("flush in done: result", DivResult, 32'hFFFFFFFF);
      stepCycle();
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flush in done: busy after", 32'(busy), 32'd0);

      // start together with flush in IDLE is dropped
      DivOp = 2'd1;
      A = 32'd5;
      B = 32'd0;
      start = 1'b1;
      flush = 1'b1;
      stepCycle();
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      checkOutput("start+flush dropped busy", 32'(busy), 32'd0);
      checkOutput("start+flush dropped result", DivResult, 32'hFFFFFFFF);

      // start during CALC and DONE is ignored, not queued
      applyStimulus(2'd0, 32'd50, 32'd5);
      repeat (4) stepCycle();
      DivOp = 2'd1;
      A = 32'd9;
      B = 32'd0;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      repeat (27) stepCycle();
      DivOp = 2'd1;
      A = 32'd100;
      B = 32'd0;
      start = 1'b1;
      @(negedge clk);
      checkOutput("ignored start: done at 33", 32'(done), 32'd1);
      checkOutput("ignored start: result", DivResult, 32'd10);
      stepCycle();
      start = 1'b0;
      @(negedge clk);
      checkOutput("ignored start: idle at 34", {30'd0, busy, done}, 32'd0);
      stepCycle();
      @(negedge clk);
      checkOutput("ignored start: not queued", {30'd0, busy, done}, 32'd0);
      checkOutput("ignored start: result held", DivResult, 32'd10);

      // Reset mid-operation clears everything and no done follows
      applyStimulus(2'd0, 32'd50, 32'd5);
      repeat (19) stepCycle();
      rst_n = 1'b0;
      stepCycle();
      @(negedge clk);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      checkOutput("mid reset done", 32'(done), 32'd0);
      checkOutput("mid reset result", DivResult, 32'd0);
      rst_n = 1'b1;
      cnt = doneCount;
      repeat (40) stepCycle();
      checkOutput("mid reset no done", 32'(doneCount - cnt), 32'd0);
      heldResult = 32'd0;
      applyStimulus(2'd1, 32'd1000, 32'd3);
      waitResult("post reset", 32'd333, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
